// File: rtl/user_rom_arbiter_pkg.sv
// Shared types and helpers for the user-domain ROM arbiter: OBI channel
// structs, index-width helper and the round-robin pick function.
package user_rom_arbiter_pkg;

    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned IdWidth   = 2;

    // Largest manager count the pick function can scan.
    localparam int unsigned MaxMgr  = 16;
    localparam int unsigned MaxIdxW = 4;

    typedef struct packed {
        logic [AddrWidth-1:0]   addr;
        logic                   we;
        logic [DataWidth/8-1:0] be;
        logic [DataWidth-1:0]   wdata;
        logic [IdWidth-1:0]     aid;
        logic                   a_optional;
    } obi_a_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
    } obi_req_t;

    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic [IdWidth-1:0]   rid;
        logic                 err;
        logic                 r_optional;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;

    // Width of an index into n entries; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First requester at or after ptr, wrapping modulo num_mgr.
    // Returns 1 when any requester was found; idx holds the winner.
    function automatic logic rr_pick(
        input  logic [MaxMgr-1:0] req_vec,
        input  int unsigned       ptr,
        input  int unsigned       num_mgr,
        output int unsigned       idx
    );
        logic        found;
        int unsigned cand;
        found = 1'b0;
        idx   = ptr;
        for (int unsigned k = 0; k < MaxMgr; k++) begin
            if (k < num_mgr) begin
                cand = (ptr + k) % num_mgr;
                if (!found && req_vec[cand[MaxIdxW-1:0]]) begin
                    found = 1'b1;
                    idx   = cand;
                end
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/user_rom_arbiter_fifo.sv
// In-order FIFO of manager indices; remembers who issued each outstanding
// transaction so responses can be routed back.
module user_rom_arbiter_fifo
    import user_rom_arbiter_pkg::*;
#(
    parameter int unsigned Width = 1,
    parameter int unsigned Depth = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push,
    input  logic                       pop,
    input  logic [Width-1:0]           wdata,
    output logic [Width-1:0]           head,
    output logic [$clog2(Depth+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PtrW = idx_width(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PtrW-1:0] bump(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CntW'(Depth));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage write; contents need no reset since count guards every read.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy update; push and pop together keep count steady.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/user_rom_arbiter.sv
// Round-robin OBI arbiter sharing one subordinate between NumMgr managers.
// A winner held off by the subordinate stays locked until granted, and
// responses are steered back in issue order through a small index FIFO.
module user_rom_arbiter #(
    parameter type         obi_req_t = user_rom_arbiter_pkg::obi_req_t,
    parameter type         obi_rsp_t = user_rom_arbiter_pkg::obi_rsp_t,
    parameter int unsigned NumMgr    = 2,
    parameter int unsigned MaxTrans  = 2
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  obi_req_t mgr_req_i [NumMgr],
    output obi_rsp_t mgr_rsp_o [NumMgr],
    output obi_req_t sbr_req_o,
    input  obi_rsp_t sbr_rsp_i,
    output logic     spurious_o
);

    import user_rom_arbiter_pkg::*;

    localparam int unsigned IdxW = idx_width(NumMgr);
    localparam int unsigned CntW = $clog2(MaxTrans + 1);

    typedef logic [IdxW-1:0] idx_t;

    idx_t              rr_q;
    logic              lock_q;
    idx_t              lock_idx_q;
    logic              spurious_q;

    logic [MaxMgr-1:0] req_vec;
    logic              pick_valid;
    int unsigned       pick_idx;
    idx_t              winner;
    logic              issue;
    logic              handshake;
    logic              rsp_hit;
    logic              spurious_d;

    idx_t              fifo_head;
    logic [CntW-1:0]   fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    // Round-robin selection, overridden by the lock while a request is pending.
    always_comb begin
        req_vec  = '0;
        pick_idx = '0;
        for (int i = 0; i < NumMgr; i++) begin
            req_vec[i] = mgr_req_i[i].req;
        end
        pick_valid = rr_pick(req_vec, 32'(rr_q), NumMgr, pick_idx);
        winner     = lock_q ? lock_idx_q : idx_t'(pick_idx);
    end

    assign issue      = pick_valid && !fifo_full && !rst_i;
    assign handshake  = issue && sbr_rsp_i.gnt;
    assign rsp_hit    = sbr_rsp_i.rvalid && (fifo_count != '0) && !rst_i;
    assign spurious_d = sbr_rsp_i.rvalid && fifo_empty && !rst_i;
    assign spurious_o = spurious_q && !rst_i;

    // Forward the winner's A channel to the subordinate.
    always_comb begin
        sbr_req_o     = '0;
        sbr_req_o.a   = mgr_req_i[winner].a;
        sbr_req_o.req = issue;
    end

    // Grant goes to the winner; the response goes to the FIFO head.
    always_comb begin
        for (int i = 0; i < NumMgr; i++) begin
            mgr_rsp_o[i]     = '0;
            mgr_rsp_o[i].gnt = handshake && (winner == idx_t'(i));
            if (rsp_hit && (fifo_head == idx_t'(i))) begin
                mgr_rsp_o[i].rvalid = 1'b1;
                mgr_rsp_o[i].r      = sbr_rsp_i.r;
            end
        end
    end

    // Pointer advance on grant, lock on stall, one-cycle spurious flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            spurious_q <= 1'b0;
        end else begin
            spurious_q <= spurious_d;
            if (handshake) begin
                rr_q   <= (winner == idx_t'(NumMgr - 1)) ? '0 : winner + 1'b1;
                lock_q <= 1'b0;
            end else if (issue) begin
                lock_q     <= 1'b1;
                lock_idx_q <= winner;
            end
        end
    end

    user_rom_arbiter_fifo #(
        .Width (IdxW),
        .Depth (MaxTrans)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (handshake),
        .pop   (rsp_hit),
        .wdata (winner),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_user_rom_arbiter.sv
// Directed vector bench for user_rom_arbiter with two managers and a
// two-deep transaction FIFO; the bench plays the subordinate.
module tb_user_rom_arbiter;

    import user_rom_arbiter_pkg::*;

    logic     clk_i = 1'b0;
    logic     rst_i = 1'b1;
    obi_req_t mgr_req_i [2];
    obi_rsp_t mgr_rsp_o [2];
    obi_req_t sbr_req_o;
    obi_rsp_t sbr_rsp_i;
    logic     spurious_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    user_rom_arbiter #(
        .NumMgr   (2),
        .MaxTrans (2)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .mgr_req_i  (mgr_req_i),
        .mgr_rsp_o  (mgr_rsp_o),
        .sbr_req_o  (sbr_req_o),
        .sbr_rsp_i  (sbr_rsp_i),
        .spurious_o (spurious_o)
    );

    // One cycle of stimulus and the outputs required in that same cycle.
    typedef struct {
        logic        rst;
        logic        req0;
        logic [31:0] addr0;
        logic        req1;
        logic [31:0] addr1;
        logic        we1;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic [1:0]  rid;
        logic        err;
        logic        e_sreq;
        logic [31:0] e_saddr;
        logic        e_gnt0;
        logic        e_gnt1;
        logic        e_rv0;
        logic        e_rv1;
        logic [31:0] e_rdata;
        logic [1:0]  e_rid;
        logic        e_err;
        logic        e_spur;
    } vec_t;

    vec_t tbl[$];

    task automatic checkOutput(input string name, input int idx,
                               input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s (step %0d): actual %h required %h", name, idx, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk_i);
        rst_i                     = v.rst;
        mgr_req_i[0]              = '0;
        mgr_req_i[0].req          = v.req0;
        mgr_req_i[0].a.addr       = v.addr0;
        mgr_req_i[0].a.be         = 4'hF;
        mgr_req_i[0].a.aid        = 2'd0;
        mgr_req_i[1]              = '0;
        mgr_req_i[1].req          = v.req1;
        mgr_req_i[1].a.addr       = v.addr1;
        mgr_req_i[1].a.we         = v.we1;
        mgr_req_i[1].a.be         = 4'hF;
        mgr_req_i[1].a.wdata      = v.we1 ? 32'hCAFE0001 : 32'h0;
        mgr_req_i[1].a.aid        = 2'd1;
        sbr_rsp_i                 = '0;
        sbr_rsp_i.gnt             = v.gnt;
        sbr_rsp_i.rvalid          = v.rvalid;
        sbr_rsp_i.r.rdata         = v.rdata;
        sbr_rsp_i.r.rid           = v.rid;
        sbr_rsp_i.r.err           = v.err;
        #1;
    endtask

    task automatic checkVector(input vec_t v, input int idx);
        checkOutput("sbr_req", idx, 32'(sbr_req_o.req), 32'(v.e_sreq));
        if (v.e_sreq) begin
            checkOutput("sbr_addr", idx, sbr_req_o.a.addr, v.e_saddr);
        end
        checkOutput("gnt0", idx, 32'(mgr_rsp_o[0].gnt), 32'(v.e_gnt0));
        checkOutput("gnt1", idx, 32'(mgr_rsp_o[1].gnt), 32'(v.e_gnt1));
        checkOutput("rvalid0", idx, 32'(mgr_rsp_o[0].rvalid), 32'(v.e_rv0));
        checkOutput("rvalid1", idx, 32'(mgr_rsp_o[1].rvalid), 32'(v.e_rv1));
        checkOutput("spurious", idx, 32'(spurious_o), 32'(v.e_spur));
        if (v.e_rv0) begin
            checkOutput("rdata0", idx, mgr_rsp_o[0].r.rdata, v.e_rdata);
            checkOutput("rid0", idx, 32'(mgr_rsp_o[0].r.rid), 32'(v.e_rid));
            checkOutput("err0", idx, 32'(mgr_rsp_o[0].r.err), 32'(v.e_err));
        end
        if (v.e_rv1) begin
            checkOutput("rdata1", idx, mgr_rsp_o[1].r.rdata, v.e_rdata);
            checkOutput("rid1", idx, 32'(mgr_rsp_o[1].r.rid), 32'(v.e_rid));
            checkOutput("err1", idx, 32'(mgr_rsp_o[1].r.err), 32'(v.e_err));
        end
    endtask

    initial begin
        mgr_req_i[0] = '0;
        mgr_req_i[1] = '0;
        sbr_rsp_i    = '0;

        // rst req0 addr0 req1 addr1 we1 gnt rvld rdata rid err | sreq saddr g0 g1 rv0 rv1 rdata rid err spur
        // Reset forces every output low, even with requests and responses present.
        tbl.push_back('{1,1,32'h00,0,32'h00,0,1,1,32'h0000_0000,2'd0,0, 0,32'h00,0,0,0,0,32'h0000_0000,2'd0,0,0});
        tbl.push_back('{1,0,32'h00,0,32'h00,0,0,0,32'h0000_0000,2'd0,0, 0,32'h00,0,0,0,0,32'h0000_0000,2'd0,0,0});
        // Single manager read with one-cycle response.
        tbl.push_back('{0,1,32'h00,0,32'h00,0,1,0,32'h0000_0000,2'd0,0, 1,32'h00,1,0,0,0,32'h0000_0000,2'd0,0,0});
        tbl.push_back('{0,0,32'h00,0,32'h00,0,0,1,32'hA5A5_0000,2'd0,0, 0,32'h00,0,0,1,0,32'hA5A5_0000,2'd0,0,0});
        // Reset again so contention starts with the pointer at manager 0.
        tbl.push_back('{1,0,32'h00,0,32'h00,0,0,0,32'h0000_0000,2'd0,0, 0,32'h00,0,0,0,0,32'h0000_0000,2'd0,0,0});
        // Contention: grants alternate 0,1,0,1 and responses follow issue order.
        tbl.push_back('{0,1,32'h10,1,32'h20,0,1,0,32'h0000_0000,2'd0,0, 1,32'h10,1,0,0,0,32'h0000_0000,2'd0,0,0});
        tbl.push_back('{0,1,32'h10,1,32'h20,0,1,1,32'h0000_00D0,2'd0,0, 1,32'h20,0,1,1,0,32'h0000_00D0,2'd0,0,0});
        tbl.push_back('{0,1,32'h10,1,32'h20,0,1,1,32'h0000_00D1,2'd1,0, 1,32'h10,1,0,0,1,32'h0000_00D1,2'd1,0,0});
        tbl.push_back('{0,1,32'h10,1,32'h20,0,1,1,32'h0000_00D2,2'd0,0, 1,32'h20,0,1,1,0,32'h0000_00D2,2'd0,0,0});
        tbl.push_back('{0,0,32'h00,0,32'h00,0,0,1,32'h0000_00D3,2'd1,0, 0,32'h00,0,0,0,1,32'h0000_00D3,2'd1,0,0});
        // Subordinate stall: mgr1 stays locked on the bus although mgr0 arrives.
        tbl.push_back('{0,0,32'h00,1,32'h30,0,0,0,32'h0000_0000,2'd0,0, 1,32'h30,0,0,0,0,32'h0000_0000,2'd0,0,0});
        tbl.push_back('{0,1,32'h40,1,32'h30,0,0,0,32'h0000_0000,2'd0,0, 1,32'h30,0,0,0,0,32'h0000_0000,2'd0,0,0});
        tbl.push_back('{0,1,32'h40,1,32'h30,0,0,0,32'h0000_0000,2'd0,0, 1,32'h30,0,0,0,0,32'h0000_0000,2'd0,0,0});
        tbl.push_back('{0,1,32'h40,1,32'h30,0,1,0,32'h0000_0000,2'd0,0, 1,32'h30,0,1,0,0,32'h0000_0000,2'd0,0,0});
        tbl.push_back('{0,1,32'h40,0,32'h00,0,1,0,32'h0000_0000,2'd0,0, 1,32'h40,1,0,0,0,32'h0000_0000,2'd0,0,0});
        tbl.push_back('{0,0,32'h00,0,32'h00,0,0,1,32'h0000_00E1,2'd1,0, 0,32'h00,0,0,0,1,32'h0000_00E1,2'd1,0,0});
        tbl.push_back('{0,0,32'h00,0,32'h00,0,0,1,32'h0000_00E0,2'd0,0, 0,32'h00,0,0,1,0,32'h0000_00E0,2'd0,0,0});
        // FIFO full: two grants, then no request until responses drain.
        tbl.push_back('{0,1,32'h50,0,32'h00,0,1,0,32'h0000_0000,2'd0,0, 1,32'h50,1,0,0,0,32'h0000_0000,2'd0,0,0});
        tbl.push_back('{0,1,32'h54,0,32'h00,0,1,0,32'h0000_0000,2'd0,0, 1,32'h54,1,0,0,0,32'h0000_0000,2'd0,0,0});
        tbl.push_back('{0,1,32'h58,0,32'h00,0,1,0,32'h0000_0000,2'd0,0, 0,32'h00,0,0,0,0,32'h0000_0000,2'd0,0,0});
        tbl.push_back('{0,1,32'h58,0,32'h00,0,1,0,32'h0000_0000,2'd0,0, 0,32'h00,0,0,0,0,32'h0000_0000,2'd0,0,0});
        tbl.push_back('{0,1,32'h58,0,32'h00,0,1,1,32'h0000_00F0,2'd0,0, 0,32'h00,0,0,1,0,32'h0000_00F0,2'd0,0,0});
        tbl.push_back('{0,1,32'h58,0,32'h00,0,1,1,32'h0000_00F1,2'd0,0, 1,32'h58,1,0,1,0,32'h0000_00F1,2'd0,0,0});
        tbl.push_back('{0,0,32'h00,0,32'h00,0,0,1,32'h0000_00F2,2'd0,0, 0,32'h00,0,0,1,0,32'h0000_00F2,2'd0,0,0});
        // Write with error response routed to mgr1 only.
        tbl.push_back('{0,0,32'h00,1,32'h60,1,1,0,32'h0000_0000,2'd0,0, 1,32'h60,0,1,0,0,32'h0000_0000,2'd0,0,0});
        tbl.push_back('{0,0,32'h00,0,32'h00,0,0,1,32'h0000_0000,2'd1,1, 0,32'h00,0,0,0,1,32'h0000_0000,2'd1,1,0});
        // Reset mid-flight: late response is dropped and flagged, pointer back at 0.
        tbl.push_back('{0,1,32'h70,0,32'h00,0,1,0,32'h0000_0000,2'd0,0, 1,32'h70,1,0,0,0,32'h0000_0000,2'd0,0,0});
        tbl.push_back('{1,0,32'h00,0,32'h00,0,0,0,32'h0000_0000,2'd0,0, 0,32'h00,0,0,0,0,32'h0000_0000,2'd0,0,0});
        tbl.push_back('{0,0,32'h00,0,32'h00,0,0,1,32'h0000_0077,2'd0,0, 0,32'h00,0,0,0,0,32'h0000_0000,2'd0,0,0});
        tbl.push_back('{0,0,32'h00,0,32'h00,0,0,0,32'h0000_0000,2'd0,0, 0,32'h00,0,0,0,0,32'h0000_0000,2'd0,0,1});
        tbl.push_back('{0,1,32'h80,1,32'h90,0,1,0,32'h0000_0000,2'd0,0, 1,32'h80,1,0,0,0,32'h0000_0000,2'd0,0,0});
        tbl.push_back('{0,0,32'h00,0,32'h00,0,0,1,32'h0000_0088,2'd0,0, 0,32'h00,0,0,1,0,32'h0000_0088,2'd0,0,0});

        foreach (tbl[i]) begin
            applyStimulus(tbl[i]);
            checkVector(tbl[i], i);
        end

        // Back-to-back stream against a one-cycle subordinate: a grant and a
        // response every cycle, so the FIFO never fills.
        for (int k = 0; k < 7; k++) begin
            @(negedge clk_i);
            rst_i               = 1'b0;
            mgr_req_i[0]        = '0;
            mgr_req_i[0].req    = (k < 6);
            mgr_req_i[0].a.addr = 32'h100 + 32'(4 * k);
            mgr_req_i[1]        = '0;
            sbr_rsp_i           = '0;
            sbr_rsp_i.gnt       = 1'b1;
            sbr_rsp_i.rvalid    = (k > 0);
            sbr_rsp_i.r.rdata   = 32'h1000 + 32'(k);
            #1;
            checkOutput("b2b_gnt0", 100 + k, 32'(mgr_rsp_o[0].gnt), 32'(k < 6));
            checkOutput("b2b_rvalid0", 100 + k, 32'(mgr_rsp_o[0].rvalid), 32'(k > 0));
            if (k > 0) begin
                checkOutput("b2b_rdata0", 100 + k, mgr_rsp_o[0].r.rdata, 32'h1000 + 32'(k));
            end
        end

        @(negedge clk_i);
        mgr_req_i[0] = '0;
        sbr_rsp_i    = '0;
        #1;
        checkOutput("idle_spurious", 200, 32'(spurious_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/user_rom_arbiter.md
Name: user_rom_arbiter

Overview:
- Round-robin OBI arbiter sharing one OBI subordinate (the user-domain ROM, or any other single-port OBI subordinate) between NumMgr managers, e.g. the core data port and a debug/DMA port.
- Forwards one winning A-channel request per cycle.
- Records the winner index in an in-order transaction FIFO and routes each R-channel response back to the manager that issued it.
- Sits in the user domain between the crossbar port and the subordinate.

Parameters:
- ObiCfg, obi_pkg::ObiDefaultConfig, OBI configuration shared by all ports.
- obi_req_t, logic, OBI request struct type.
- obi_rsp_t, logic, OBI response struct type.
- NumMgr, 2, number of managers; must be >= 2.
- MaxTrans, 2, outstanding transactions tracked (FIFO depth); must be >= 1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- mgr_req_i  in  NumMgr x obi_req_t  manager requests
- mgr_rsp_o  out  NumMgr x obi_rsp_t  manager responses
- sbr_req_o  out  obi_req_t  request to the shared subordinate
- sbr_rsp_i  in  obi_rsp_t  subordinate response
- spurious_o  out  1  one-cycle pulse when an rvalid arrives with the FIFO empty

Behaviour:
- Clocking/reset:
  - One clock, clk_i.
  - rst_i is synchronous and active-high.
  - While rst_i = 1, all outputs are forced low: sbr_req_o.req = 0, every mgr_rsp_o[i].gnt = 0, every mgr_rsp_o[i].rvalid = 0, spurious_o = 0.
  - Reset clears rr_q = 0, lock_q = 0, lock_idx_q = 0, the FIFO (count = 0) and spurious_q = 0.
- Arbitration:
  - Pointer rr_q has width $clog2(NumMgr).
  - Winner = first i with mgr_req_i[i].req = 1, scanning rr_q, rr_q+1, ..., wrapping modulo NumMgr.
  - If lock_q = 1, the winner is lock_idx_q regardless of the scan.
- Issue:
  - sbr_req_o.a = mgr_req_i[winner].a.
  - sbr_req_o.req = (any req) && (count < MaxTrans).
  - When the FIFO is full, issue stalls and no gnt is given; full stalls even if a pop occurs in the same cycle.
- Grant:
  - mgr_rsp_o[winner].gnt = sbr_rsp_i.gnt && sbr_req_o.req.
  - All other gnt = 0; the grant path is combinational, 0 added cycles.
- Handshake (sbr_req_o.req && sbr_rsp_i.gnt):
  - Push winner into the FIFO.
  - rr_q <= (winner + 1) mod NumMgr.
  - lock_q <= 0.
- Stall (sbr_req_o.req && !sbr_rsp_i.gnt):
  - lock_q <= 1, lock_idx_q <= winner.
  - The winner is held until granted, preserving OBI request stability.
  - A higher-priority arrival never preempts a pending request.
- Response:
  - On sbr_rsp_i.rvalid with count > 0: h = FIFO head.
  - mgr_rsp_o[h].rvalid = 1 and mgr_rsp_o[h].r = sbr_rsp_i.r (rdata, rid, err, r_optional passed unchanged); pop the head.
  - All other managers: rvalid = 0, r = '0.
  - Response routing is combinational from the FIFO head, 0 added cycles.
- Simultaneous push and pop: count stays unchanged and head and tail both advance. With a 1-cycle-latency subordinate, back-to-back issue therefore proceeds at 1 transaction per cycle.
- Spurious response: sbr_rsp_i.rvalid with count = 0 is dropped (no manager sees rvalid). spurious_q <= 1 for exactly one cycle; spurious_o = spurious_q.
- Wrap-around: FIFO read/write pointers wrap modulo MaxTrans; rr_q wraps NumMgr-1 -> 0.
- Reset mid-operation:
  - Outstanding entries are discarded.
  - Responses arriving after reset deassertion for pre-reset requests are flagged spurious and dropped.
- Latency: none added on either channel; the arbiter is transparent apart from the selection.

Decomposition:
- user_rom_arbiter_pkg holds:
  - idx_t = logic [$clog2(NumMgr)-1:0] (exported as a localparam-based width function);
  - function rr_pick(req_vec, ptr) returning the winner index and a valid bit.
- Sub-module user_rom_arbiter_fifo: synchronous FIFO of idx_t, depth MaxTrans.
  - Ports: push, pop, data in, head out, count, full, empty.
  - Same-cycle push and pop are supported when not empty.
- Round-robin pick logic and the lock register stay in the top module.

Test Plan:
- Single manager: mgr0 reads addr 0x0, subordinate grants at once and returns rdata 0xA5A50000 one cycle later -> mgr0 gnt in cycle 0, rvalid with rdata 0xA5A50000 in cycle 1; mgr1 rvalid = 0 throughout.
- Contention, both managers request every cycle, rr_q = 0 after reset -> grants alternate mgr0, mgr1, mgr0, mgr1; responses route to mgr0, mgr1, mgr0, mgr1 in order; rid of each equals the issuing manager's aid.
- Subordinate stall: mgr1 requests with gnt held low 3 cycles, mgr0 raises req in cycle 1 -> sbr_req_o.a stays equal to mgr1's request for all stall cycles; mgr1 is granted in cycle 3; mgr0 is granted in cycle 4.
- FIFO full: MaxTrans = 2, subordinate delays rvalid 4 cycles -> exactly 2 grants issued, then sbr_req_o.req = 0 until the first rvalid; no third gnt while count = 2.
- Write error: mgr1 issues we = 1, subordinate returns err = 1 -> mgr1 rvalid with err = 1; mgr0 unaffected.
- Reset mid-flight: mgr0 granted, rst_i pulsed for 1 cycle before the rvalid, rvalid arrives after reset -> no manager rvalid, spurious_o = 1 for one cycle, rr_q = 0.
